// File: rtl/ac97_pkg.sv
// ac97_pkg: shared AC'97 frame geometry, deframer state encoding and slot-boundary helper
package ac97_pkg;

    localparam int AC97_FRAME_BITS = 256;
    localparam int AC97_TAG_BITS   = 16;
    localparam int AC97_SLOT_BITS  = 20;
    localparam int AC97_NUM_SLOTS  = 12;

    typedef enum logic {HUNT, RUN} state_t;

    // True when frame bit b is the last (LSB) bit of one of the twelve slots.
    function automatic logic is_slot_end(input logic [7:0] b);
        int first_end;
        first_end = AC97_TAG_BITS + AC97_SLOT_BITS - 1;
        return (int'(b) >= first_end) && ((int'(b) - first_end) % AC97_SLOT_BITS == 0)
               && ((int'(b) - first_end) / AC97_SLOT_BITS < AC97_NUM_SLOTS);
    endfunction

endpackage

// File: rtl/ac97_deframer.sv
// ac97_deframer: aligns to SYNC and splits each 256-bit AC'97 frame into tag and slot words
// Ports: ac97_clk/ac97_rst_n clock and async active-low reset; sin/sync falling-edge-sampled
// link bits; tag/tag_stb tag word; slot_data/slot_idx/slot_valid/slot_stb slot words;
// frame_stb end of frame; locked alignment status; sync_err/err_count framing errors;
// frame_count complete frames received.
module ac97_deframer
    import ac97_pkg::*;
#(
    parameter int SYNC_LEN    = 16,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        ac97_clk,
    input  logic        ac97_rst_n,
    input  logic        sin,
    input  logic        sync,
    output logic [15:0] tag,
    output logic        tag_stb,
    output logic [19:0] slot_data,
    output logic [3:0]  slot_idx,
    output logic        slot_valid,
    output logic        slot_stb,
    output logic        frame_stb,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_count,
    output logic [15:0] frame_count
);

    localparam logic [8:0] SYNC_LEN_W = 9'(SYNC_LEN);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [19:0] sh;
    logic [3:0]  slot_n;
    logic [3:0]  clean;
    logic [3:0]  clean_inc;
    logic        sync_prev;
    logic        rise, err, restart, tag_end, slot_done, frame_end;

    assign rise      = sync & ~sync_prev;
    assign clean_inc = (clean == 4'hF) ? clean : clean + 4'd1;

    // An early rise restarts the frame on the current bit, so no field of the
    // aborted frame completes on it; a level mismatch still lets the bit finish its field.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        err       = 1'b0;
        restart   = 1'b0;
        tag_end   = 1'b0;
        slot_done = 1'b0;
        frame_end = 1'b0;
        if (state == HUNT) begin
            if (rise) begin
                state_nx = RUN;
                cnt_nx   = 8'd1;
                restart  = 1'b1;
            end
        end else if (rise) begin
            err     = cnt != 8'd0;
            cnt_nx  = 8'd1;
            restart = 1'b1;
        end else if (cnt == 8'd0) begin
            err      = 1'b1;
            state_nx = HUNT;
        end else begin
            cnt_nx    = cnt + 8'd1;
            tag_end   = cnt == 8'(AC97_TAG_BITS - 1);
            slot_done = is_slot_end(cnt);
            frame_end = cnt == 8'(AC97_FRAME_BITS - 1);
            if (sync != ({1'b0, cnt} < SYNC_LEN_W)) begin
                err      = 1'b1;
                state_nx = HUNT;
            end
        end
    end

    always_ff @(posedge ac97_clk or negedge ac97_rst_n) begin
        if (!ac97_rst_n) begin
            state       <= HUNT;
            cnt         <= 8'd0;
            sh          <= 20'd0;
            slot_n      <= 4'd0;
            clean       <= 4'd0;
            sync_prev   <= 1'b0;
            tag         <= 16'd0;
            tag_stb     <= 1'b0;
            slot_data   <= 20'd0;
            slot_idx    <= 4'd0;
            slot_valid  <= 1'b0;
            slot_stb    <= 1'b0;
            frame_stb   <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= 8'd0;
            frame_count <= 16'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sync_prev <= sync;
            sh        <= {sh[18:0], sin};
            slot_n    <= restart ? 4'd1 : (slot_done ? slot_n + 4'd1 : slot_n);
            tag_stb   <= tag_end;
            slot_stb  <= slot_done;
            frame_stb <= frame_end;
            sync_err  <= err;
            if (tag_end)
                tag <= {sh[14:0], sin};
            if (slot_done) begin
                slot_data  <= {sh[18:0], sin};
                slot_idx   <= slot_n;
                slot_valid <= tag[4'd15 - slot_n];
            end
            if (frame_end)
                frame_count <= frame_count + 16'd1;
            if (err) begin
                clean     <= 4'd0;
                locked    <= 1'b0;
                err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            end else if (frame_end) begin
                clean  <= clean_inc;
                locked <= locked | (clean_inc >= 4'(LOCK_FRAMES));
            end
        end
    end

endmodule
